// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/grant/response channel,
// redirect input from the PC adders, and the valid/ready channel to decode.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output if_valid, if_instr, if_pc, if_pc_plus4,
    input  if_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  if_valid, if_instr, if_pc, if_pc_plus4,
    output if_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: single-outstanding word fetches from instruction
// memory, buffered with their PC in a small FIFO that feeds decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  instr_fetch_unit_if.master    bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        instr_mem_q [DEPTH];
  logic [31:0]        instr_mem_d [DEPTH];
  logic [31:0]        pc_mem_q    [DEPTH];
  logic [31:0]        pc_mem_d    [DEPTH];

  logic req, push, pop;

  // Redirect suppresses both the request and any FIFO traffic in its cycle.
  assign req  = resetn && (state_q == IDLE) && (count_q < CNT_W'(DEPTH)) && !bus.redirect_valid;
  assign push = (state_q == WAIT) && bus.imem_rvalid && !bus.redirect_valid;
  assign pop  = (count_q != '0) && bus.if_ready && !bus.redirect_valid;

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.if_valid    = (count_q != '0);
  assign bus.if_instr    = instr_mem_q[rd_ptr_q];
  assign bus.if_pc       = pc_mem_q[rd_ptr_q];
  assign bus.if_pc_plus4 = pc_mem_q[rd_ptr_q] + 32'd4;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;

    case (state_q)
      IDLE: begin
        if (req && bus.imem_gnt) begin
          state_d    = WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      WAIT: begin
        // A response landing with a redirect is consumed and dropped.
        if (bus.imem_rvalid)         state_d = IDLE;
        else if (bus.redirect_valid) state_d = DISCARD;
      end
      DISCARD: begin
        if (bus.imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      instr_mem_d[wr_ptr_q] = bus.imem_rdata;
      pc_mem_d[wr_ptr_q]    = req_pc_q;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);

    if (bus.redirect_valid) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: scripted memory responder, a queue-based
// reference model checked every cycle, and directed literal checkpoints.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 2;

  logic clk;
  logic resetn;
  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // responder controls
  int          lat      = 1;
  int          gnt_low  = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  // reference model state
  bit          model_en = 0;
  logic [63:0] m_q[$];
  bit          m_out  = 0;
  bit          m_keep = 0;
  logic [31:0] m_out_addr = '0;
  logic [31:0] m_pc = RESET_PC;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: note any grant, then drive the memory side for the next cycle.
  task automatic cyc();
    bit          g;
    logic [31:0] ga;
    @(negedge clk);
    g  = bus.imem_req && bus.imem_gnt;
    ga = bus.imem_addr;
    @(posedge clk);
    #1;
    bus.imem_rvalid = 1'b0;
    if (!resetn) begin
      pend_cnt = 0;
    end else begin
      if (g) begin
        pend_cnt  = lat;
        pend_addr = ga;
      end
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = 32'hA0 + pend_addr;
        end
      end
    end
    bus.imem_gnt = (gnt_low == 0);
    if (gnt_low > 0) gnt_low--;
  endtask

  task automatic do_reset(input bit rdy);
    resetn             = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.if_ready       = rdy;
    lat                = 1;
    gnt_low            = 0;
    repeat (3) cyc();
    resetn       = 1'b1;
    bus.imem_gnt = 1'b1;
    #1;
  endtask

  // Compare DUT against the model, then advance the model by this cycle's inputs.
  always @(negedge clk) begin : cmp
    logic exp_req;
    logic [63:0] head;
    if (model_en) begin
      exp_req = resetn && !m_out && (m_q.size() < DEPTH) && !bus.redirect_valid;
      chk("m_imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
      chk("m_imem_addr", bus.imem_addr, m_pc);
      chk("m_if_valid", {31'd0, bus.if_valid}, {31'd0, m_q.size() > 0});
      if (m_q.size() > 0) begin
        head = m_q[0];
        chk("m_if_pc", bus.if_pc, head[63:32]);
        chk("m_if_instr", bus.if_instr, head[31:0]);
        chk("m_if_pc_plus4", bus.if_pc_plus4, head[63:32] + 32'd4);
      end
      if (!resetn) begin
        m_q.delete();
        m_out = 0;
        m_pc  = RESET_PC;
      end else if (bus.redirect_valid) begin
        if (m_out && bus.imem_rvalid) m_out = 0;
        else if (m_out)               m_keep = 0;
        m_q.delete();
        m_pc = {bus.redirect_pc[31:2], 2'b00};
      end else begin
        if (m_q.size() > 0 && bus.if_ready) void'(m_q.pop_front());
        if (m_out && bus.imem_rvalid) begin
          if (m_keep) m_q.push_back({m_out_addr, bus.imem_rdata});
          m_out = 0;
        end
        if (exp_req && bus.imem_gnt) begin
          m_out      = 1;
          m_keep     = 1;
          m_out_addr = m_pc;
          m_pc       = m_pc + 32'd4;
        end
      end
    end
  end

  initial begin
    resetn             = 1'b0;
    bus.imem_gnt       = 1'b1;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.if_ready       = 1'b1;
    repeat (2) cyc();
    model_en = 1;

    // reset values
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h100);
    chk("rst_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rst_instr", bus.if_instr, 32'd0);
    chk("rst_pc", bus.if_pc, 32'd0);
    chk("rst_pc4", bus.if_pc_plus4, 32'd4);

    // streaming fetch, 2-cycle cadence
    do_reset(1'b1);
    chk("t1_c0_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t1_c0_addr", bus.imem_addr, 32'h100);
    cyc();
    chk("t1_c1_valid", {31'd0, bus.if_valid}, 32'd0);
    cyc();
    chk("t1_c2_valid", {31'd0, bus.if_valid}, 32'd1);
    chk("t1_c2_pc", bus.if_pc, 32'h100);
    chk("t1_c2_instr", bus.if_instr, 32'h1A0);
    chk("t1_c2_pc4", bus.if_pc_plus4, 32'h104);
    cyc();
    chk("t1_c3_valid", {31'd0, bus.if_valid}, 32'd0);
    cyc();
    chk("t1_c4_pc", bus.if_pc, 32'h104);
    chk("t1_c4_pc4", bus.if_pc_plus4, 32'h108);
    repeat (2) cyc();
    chk("t1_c6_pc", bus.if_pc, 32'h108);
    chk("t1_c6_pc4", bus.if_pc_plus4, 32'h10C);
    chk("t1_c6_instr", bus.if_instr, 32'h1A8);

    // FIFO fills with decode stalled, then drains
    do_reset(1'b0);
    repeat (8) cyc();
    chk("t2_full_req", {31'd0, bus.imem_req}, 32'd0);
    chk("t2_full_addr", bus.imem_addr, 32'h108);
    chk("t2_full_pc", bus.if_pc, 32'h100);
    bus.if_ready = 1'b1;
    #1;
    chk("t2_pop_req", {31'd0, bus.imem_req}, 32'd0);
    cyc();
    chk("t2_after_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t2_after_pc", bus.if_pc, 32'h104);
    repeat (4) cyc();

    // grant withheld for 3 cycles
    do_reset(1'b1);
    bus.imem_gnt = 1'b0;
    gnt_low      = 2;
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_req", {31'd0, bus.imem_req}, 32'd1);
      chk("t3_hold_addr", bus.imem_addr, 32'h100);
      cyc();
    end
    chk("t3_gnt_req", {31'd0, bus.imem_req}, 32'd1);
    cyc();
    chk("t3_c4_valid", {31'd0, bus.if_valid}, 32'd0);
    cyc();
    chk("t3_c5_pc", bus.if_pc, 32'h100);
    chk("t3_c5_instr", bus.if_instr, 32'h1A0);
    repeat (3) cyc();

    // redirect while waiting; late response discarded
    do_reset(1'b1);
    lat = 3;
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h203;
    #1;
    chk("t4_redir_req", {31'd0, bus.imem_req}, 32'd0);
    cyc();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t4_disc_req", {31'd0, bus.imem_req}, 32'd0);
    chk("t4_disc_addr", bus.imem_addr, 32'h200);
    cyc();
    lat = 1;
    chk("t4_c3_valid", {31'd0, bus.if_valid}, 32'd0);
    cyc();
    chk("t4_c4_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t4_c4_addr", bus.imem_addr, 32'h200);
    repeat (2) cyc();
    chk("t4_c6_pc", bus.if_pc, 32'h200);
    chk("t4_c6_instr", bus.if_instr, 32'h2A0);
    repeat (2) cyc();

    // redirect coincides with response and a pending pop
    do_reset(1'b0);
    repeat (3) cyc();
    chk("t5_rvalid_here", {31'd0, bus.imem_rvalid}, 32'd1);
    bus.if_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h300;
    #1;
    chk("t5_valid_before", {31'd0, bus.if_valid}, 32'd1);
    cyc();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t5_flushed", {31'd0, bus.if_valid}, 32'd0);
    chk("t5_addr", bus.imem_addr, 32'h300);
    chk("t5_req", {31'd0, bus.imem_req}, 32'd1);
    repeat (2) cyc();
    chk("t5_pc", bus.if_pc, 32'h300);
    repeat (2) cyc();

    // wrap at top of address space, then reset mid-transaction
    do_reset(1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    cyc();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t6_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t6_addr", bus.imem_addr, 32'hFFFF_FFFC);
    repeat (2) cyc();
    chk("t6_top_pc", bus.if_pc, 32'hFFFF_FFFC);
    chk("t6_top_pc4", bus.if_pc_plus4, 32'h0);
    chk("t6_wrap_addr", bus.imem_addr, 32'h0);
    cyc();
    lat = 3;
    cyc();
    chk("t6_zero_pc", bus.if_pc, 32'h0);
    cyc();
    resetn = 1'b0;
    #1;
    chk("t6_rst_req", {31'd0, bus.imem_req}, 32'd0);
    cyc();
    chk("t6_rst_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("t6_rst_addr", bus.imem_addr, 32'h100);
    chk("t6_rst_pc", bus.if_pc, 32'h0);
    lat    = 1;
    resetn = 1'b1;
    #1;
    chk("t6_rel_req", {31'd0, bus.imem_req}, 32'd1);
    repeat (2) cyc();
    chk("t6_rel_pc", bus.if_pc, 32'h100);
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
